ro_reader: RTL and testbench

- Read-out initiator for the ADC event buffer. It sits between the host-side data path and the acquisition control state machine.
- On a host request it raises ROREQUEST and waits for the control FSM to grant RO_ENABLE. It then reads NSAMP samples from the circular sample RAM, starting PRETRIG samples before the trigger address, and streams them out over a valid/ready interface.
- It finishes by dropping ROREQUEST and pulsing RODONE_n low for one cycle.

---
 rtl/ro_reader_pkg.sv | 26 ++
 rtl/ro_reader_if.sv | 36 +++
 rtl/ro_skid_buf.sv | 72 +++++++
 rtl/ro_reader.sv | 134 +++++++++++++
 tb/tb_ro_reader.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ro_reader_pkg.sv
// ro_reader_pkg
// Shared definitions for the ADC event-buffer read-out initiator:
//   - default parameter values (address/data width, event size, pre-trigger)
//   - read-out state encoding
//   - counter width helper (a counter that must hold the value n)
package ro_reader_pkg;

   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_NSAMP   = 1024;
   localparam int DEF_PRETRIG = 64;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Bits needed to represent every value 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ro_reader_if.sv
// ro_reader_if
// Bundles the host request, control-FSM handshake, sample-RAM read port and
// output stream of the read-out initiator.
//   master : the ro_reader side (drives request/handshake, RAM read, stream)
//   slave  : the environment (host, control FSM, RAM, stream sink)
interface ro_reader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) ();
   logic              host_req;
   logic [ADDR_W-1:0] trig_addr;
   logic              RO_ENABLE;
   logic              ROREQUEST;
   logic              RODONE_n;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              ro_abort;

   modport master (
      input  host_req, trig_addr, RO_ENABLE, mem_rdata, out_ready,
      output ROREQUEST, RODONE_n, mem_rd_en, mem_addr,
             out_data, out_valid, out_last, busy, ro_abort
   );

   modport slave (
      output host_req, trig_addr, RO_ENABLE, mem_rdata, out_ready,
      input  ROREQUEST, RODONE_n, mem_rd_en, mem_addr,
             out_data, out_valid, out_last, busy, ro_abort
   );
endinterface

// File: rtl/ro_skid_buf.sv
// ro_skid_buf
// Two-entry FIFO that catches RAM read data so the stream can stall without
// losing words already requested.
//   clk, rst_n  : clock, asynchronous active-low reset (clears data and count)
//   flush       : drop all contents; wins over push and pop
//   push/push_data : write one word
//   pop         : remove the head word
//   occupancy   : number of stored words, 0..2
//   head        : oldest stored word
module ro_skid_buf #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        occupancy,
   output logic [DATA_W-1:0] head
);
   logic              wr_ptr_reg, rd_ptr_reg;
   logic [1:0]        cnt_reg, cnt_next;
   logic              push_ok, pop_ok;
   logic [DATA_W-1:0] entry_q [2];

   // Guard against misuse so the count can never leave 0..2.
   assign pop_ok  = pop && (cnt_reg != 2'd0);
   assign push_ok = push && ((cnt_reg != 2'd2) || pop_ok);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gen_entry
         logic [DATA_W-1:0] entry_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               entry_reg <= '0;
            else if (push_ok && !flush && (wr_ptr_reg == 1'(gi)))
               entry_reg <= push_data;
         end
         assign entry_q[gi] = entry_reg;
      end
   endgenerate

   always_comb begin
      cnt_next = cnt_reg;
      if (flush)
         cnt_next = 2'd0;
      else
         cnt_next = cnt_reg + {1'b0, push_ok} - {1'b0, pop_ok};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         cnt_reg    <= 2'd0;
      end else begin
         cnt_reg <= cnt_next;
         if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
         end else begin
            if (push_ok) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_ok)  rd_ptr_reg <= ~rd_ptr_reg;
         end
      end
   end

   assign occupancy = cnt_reg;
   assign head      = entry_q[rd_ptr_reg];
endmodule

// File: rtl/ro_reader.sv
// ro_reader
// Read-out initiator for the ADC event buffer. On a host request it asks the
// acquisition control FSM for the buffer (ROREQUEST), waits for RO_ENABLE,
// reads NSAMP samples from the circular RAM starting PRETRIG before the
// trigger address and streams them out; it ends with a one-cycle RODONE_n
// low pulse. Dropping RO_ENABLE mid-readout aborts the event.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : host request, control handshake, RAM read port, stream
module ro_reader
   import ro_reader_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int NSAMP   = DEF_NSAMP,
   parameter int PRETRIG = DEF_PRETRIG
) (
   input  logic        clk,
   input  logic        rst_n,
   ro_reader_if.master bus
);
   localparam int CNT_W = cnt_width(NSAMP);
   localparam logic [CNT_W-1:0] NSAMP_C = CNT_W'(NSAMP);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(NSAMP - 1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] start_reg, start_next;
   logic [CNT_W-1:0]  rd_cnt_reg, rd_cnt_next;
   logic [CNT_W-1:0]  out_cnt_reg, out_cnt_next;
   logic              inflight_reg, inflight_next;
   logic              ro_abort_reg, ro_abort_next;

   logic [1:0]        occ;
   logic [DATA_W-1:0] head;
   logic              active, abort, valid, pop, last, rd_en;
   logic [2:0]        fill;

   ro_skid_buf #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (abort),
      .push      (inflight_reg),
      .push_data (bus.mem_rdata),
      .pop       (pop),
      .occupancy (occ),
      .head      (head)
   );

   always_comb begin
      active = (state_reg == READ) || (state_reg == DRAIN);
      abort  = active && !bus.RO_ENABLE;
      valid  = (occ != 2'd0);
      pop    = valid && bus.out_ready;
      last   = valid && (out_cnt_reg == LAST_C);
      // Slots that will still be claimed after this cycle's transfer; a new
      // read is only issued if its data is guaranteed a place to land.
      fill   = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};
      // RO_ENABLE gating keeps the RAM quiet in the cycle that aborts.
      rd_en  = (state_reg == READ) && bus.RO_ENABLE &&
               (rd_cnt_reg < NSAMP_C) && (fill < 3'd2);
   end

   always_comb begin
      state_next    = state_reg;
      start_next    = start_reg;
      rd_cnt_next   = rd_cnt_reg;
      out_cnt_next  = out_cnt_reg;
      ro_abort_next = ro_abort_reg;
      inflight_next = rd_en;

      if (rd_en) rd_cnt_next  = rd_cnt_reg + 1'b1;
      if (pop)   out_cnt_next = out_cnt_reg + 1'b1;

      case (state_reg)
         IDLE: begin
            if (bus.host_req) begin
               start_next    = bus.trig_addr - ADDR_W'(PRETRIG);
               rd_cnt_next   = '0;
               out_cnt_next  = '0;
               ro_abort_next = 1'b0;
               state_next    = REQ;
            end
         end
         REQ: begin
            if (bus.RO_ENABLE) state_next = READ;
         end
         READ: begin
            if (abort) begin
               ro_abort_next = 1'b1;
               state_next    = DONE;
            end else if (rd_en && (rd_cnt_reg == LAST_C)) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (abort) begin
               ro_abort_next = 1'b1;
               state_next    = DONE;
            end else if (pop && last) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         start_reg    <= '0;
         rd_cnt_reg   <= '0;
         out_cnt_reg  <= '0;
         inflight_reg <= 1'b0;
         ro_abort_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         start_reg    <= start_next;
         rd_cnt_reg   <= rd_cnt_next;
         out_cnt_reg  <= out_cnt_next;
         inflight_reg <= inflight_next;
         ro_abort_reg <= ro_abort_next;
      end
   end

   assign bus.ROREQUEST = (state_reg == REQ) || active;
   assign bus.RODONE_n  = (state_reg != DONE);
   assign bus.busy      = (state_reg != IDLE);
   assign bus.mem_rd_en = rd_en;
   assign bus.mem_addr  = start_reg + ADDR_W'(rd_cnt_reg);
   assign bus.out_data  = head;
   assign bus.out_valid = valid;
   assign bus.out_last  = last;
   assign bus.ro_abort  = ro_abort_reg;
endmodule

// File: tb/tb_ro_reader.sv
// tb_ro_reader
// Randomised bench for ro_reader (ADDR_W=4, NSAMP=8, PRETRIG=3) against a
// RAM holding address + 0x100. Expected read addresses and stream words are
// computed directly as (trig - PRETRIG + i) mod 16.
module tb_ro_reader;
   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 16;
   localparam int NSAMP   = 8;
   localparam int PRETRIG = 3;
   localparam int DEPTH   = 1 << ADDR_W;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   ro_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   ro_reader #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSAMP(NSAMP), .PRETRIG(PRETRIG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Sample RAM: registered read, contents address + 0x100.
   always @(posedge clk)
      if (bus.mem_rd_en) bus.mem_rdata <= 16'h0100 + 16'(bus.mem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int ev_addr(input int trig, input int i);
      return (trig - PRETRIG + i) & (DEPTH - 1);
   endfunction

   task automatic reset_checks(input string pfx);
      chk({pfx, "_rorequest"}, 32'(bus.ROREQUEST), 0);
      chk({pfx, "_rodone_n"},  32'(bus.RODONE_n),  1);
      chk({pfx, "_rd_en"},     32'(bus.mem_rd_en), 0);
      chk({pfx, "_addr"},      32'(bus.mem_addr),  0);
      chk({pfx, "_valid"},     32'(bus.out_valid), 0);
      chk({pfx, "_data"},      32'(bus.out_data),  0);
      chk({pfx, "_last"},      32'(bus.out_last),  0);
      chk({pfx, "_busy"},      32'(bus.busy),      0);
      chk({pfx, "_abort"},     32'(bus.ro_abort),  0);
   endtask

   // mode: 0 ready high, 1 random ready, 2 ready toggling 1,0,1,0
   // abort_after: drop RO_ENABLE once this many words accepted (-1 = never)
   // reset_at / inject_at: READ-phase cycle for async reset / stray host_req
   task automatic run_event(input int trig, input int mode, input int abort_after,
                            input int reset_at, input int inject_at);
      int   issued, accepted, first_rd, first_xfer, last_xfer;
      bit   prev_stall, saw_last, abort_pend, aborting, finished;
      logic [DATA_W-1:0] prev_data;

      issued = 0; accepted = 0; first_rd = -1; first_xfer = -1; last_xfer = -1;
      prev_stall = 0; saw_last = 0; abort_pend = 0; aborting = 0; finished = 0;
      prev_data = '0;

      @(negedge clk); #1;
      chk("idle_busy", 32'(bus.busy), 0);
      bus.trig_addr = ADDR_W'(trig);
      bus.host_req  = 1'b1;
      @(negedge clk);
      bus.host_req  = 1'b0;
      #1;
      chk("req_rorequest", 32'(bus.ROREQUEST), 1);
      chk("req_busy",      32'(bus.busy), 1);
      chk("req_abort_clr", 32'(bus.ro_abort), 0);
      repeat (3) begin
         @(negedge clk); #1;
         chk("req_wait_rd_en", 32'(bus.mem_rd_en), 0);
         chk("req_wait_rorequest", 32'(bus.ROREQUEST), 1);
      end
      bus.RO_ENABLE = 1'b1;

      for (int cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (abort_pend) begin
            bus.RO_ENABLE = 1'b0;
            bus.out_ready = 1'b0;
            aborting      = 1;
            abort_pend    = 0;
         end else if (!aborting) begin
            case (mode)
               0:       bus.out_ready = 1'b1;
               1:       bus.out_ready = 1'($urandom_range(0, 1));
               default: bus.out_ready = ((cyc % 2) == 0);
            endcase
         end
         if (cyc == inject_at) begin
            bus.host_req  = 1'b1;
            bus.trig_addr = ADDR_W'(trig + 7);
         end else begin
            bus.host_req  = 1'b0;
         end
         #1;
         if (cyc == reset_at) begin
            #2 rst_n = 1'b0;
            #1 reset_checks("async_rst");
            @(negedge clk);
            bus.RO_ENABLE = 1'b0;
            bus.out_ready = 1'b0;
            rst_n = 1'b1;
            $display("[TB] event trig=%0d reset after %0d words", trig, accepted);
            return;
         end
         if (!bus.RODONE_n) begin
            finished = 1;
            break;
         end
         if (bus.mem_rd_en) begin
            chk("rd_addr", 32'(bus.mem_addr), 32'(ev_addr(trig, issued)));
            if (first_rd < 0) first_rd = cyc;
            issued++;
         end
         if (prev_stall) begin
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_data",  32'(bus.out_data), 32'(prev_data));
         end
         if (bus.out_valid)
            chk("last_flag", 32'(bus.out_last), 32'(accepted == NSAMP - 1));
         if (bus.out_last) saw_last = 1;
         if (bus.out_valid && bus.out_ready) begin
            chk("data", 32'(bus.out_data), 32'(16'h0100 + ev_addr(trig, accepted)));
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            accepted++;
            if (accepted == abort_after) abort_pend = 1;
         end
         chk("outstanding", 32'((issued - accepted) <= 2 && issued <= NSAMP), 1);
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
      end

      if (!finished) chk("timeout", 0, 1);
      chk("done_rorequest", 32'(bus.ROREQUEST), 0);
      chk("done_busy",      32'(bus.busy), 1);
      if (abort_after >= 0) begin
         chk("abort_flag",     32'(bus.ro_abort), 1);
         chk("abort_rd_en",    32'(bus.mem_rd_en), 0);
         chk("abort_valid",    32'(bus.out_valid), 0);
         chk("abort_no_last",  32'(saw_last), 0);
         chk("abort_accepted", 32'(accepted), 32'(abort_after));
      end else begin
         chk("ro_abort_clear", 32'(bus.ro_abort), 0);
         chk("n_accepted",     32'(accepted), NSAMP);
         chk("n_issued",       32'(issued), NSAMP);
         chk("saw_last",       32'(saw_last), 1);
         chk("first_rd_cycle", 32'(first_rd), 0);
         if (mode == 0) begin
            chk("first_latency", 32'(first_xfer - first_rd), 2);
            chk("burst_len",     32'(last_xfer - first_xfer), NSAMP - 1);
         end
      end
      @(negedge clk);
      bus.RO_ENABLE = 1'b0;
      #1;
      chk("after_rodone_n", 32'(bus.RODONE_n), 1);
      chk("after_busy",     32'(bus.busy), 0);
      $display("[TB] event trig=%0d mode=%0d words=%0d abort=%0d",
               trig, mode, accepted, bus.ro_abort);
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      rst_n         = 1'b0;
      bus.host_req  = 1'b0;
      bus.trig_addr = '0;
      bus.RO_ENABLE = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 reset_checks("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_event(5, 0, -1, -1, -1);     // basic
      run_event(1, 0, -1, -1, -1);     // address wrap
      run_event(9, 2, -1, -1, -1);     // toggling ready
      repeat (4) run_event(int'($urandom_range(0, DEPTH - 1)), 1, -1, -1, -1);
      run_event(5, 0, 3, -1, -1);      // abort after 3 words
      run_event(5, 0, -1, -1, -1);     // new event clears ro_abort
      run_event(7, 0, 3, -1, -1);      // leave ro_abort set before reset
      run_event(7, 0, -1, 4, -1);      // async reset mid-READ
      run_event(5, 0, -1, -1, -1);     // rerun basic after reset
      run_event(12, 1, -1, -1, 3);     // stray host_req during READ
      run_event(int'($urandom_range(0, DEPTH - 1)), 2, 5, -1, -1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
